jk_bank_seq: RTL and testbench

//  Command sequencer for a bank of WIDTH external jk_ff cells sharing one clk.
//  - Accepts one command per transaction: op, bit index, repeat count.
//  - Drives that cell's J/K inputs one pulse at a time.
//  - Checks the cell's Q after every pulse and reports done/err.
//  - Sits between a register/host interface and the flip-flop bank.

---
 rtl/jk_bank_seq.sv | 155 +++++++++++++++
 tb/tb_jk_bank_seq.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/jk_bank_seq.sv
`default_nettype none
// ============================================================================
// Module      : jk_bank_seq
// Description : Command sequencer for a bank of external JK flip-flop cells.
//               It pulses J/K on one cell, then checks that cell's Q after each pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module jk_bank_seq #(
    parameter int WIDTH = 8,
    parameter int IDX_W = 3,
    parameter int REP_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [IDX_W-1:0] cmd_idx,
    input  logic [REP_W-1:0] cmd_rep,
    input  logic [WIDTH-1:0] q_i,
    output logic [WIDTH-1:0] j_o,
    output logic [WIDTH-1:0] k_o,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] q_snap
);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_apply = 2'd1;
    localparam logic [1:0] c_st_check = 2'd2;
    localparam logic [1:0] c_st_done  = 2'd3;

    localparam logic [1:0] c_op_hold  = 2'b00;
    localparam logic [1:0] c_op_reset = 2'b01;
    localparam logic [1:0] c_op_set   = 2'b10;

    logic [1:0]       r_state;
    logic [1:0]       w_next;
    logic [1:0]       r_op;
    logic [WIDTH-1:0] r_sel;
    logic [REP_W-1:0] r_rem;
    logic             r_exp;
    logic             r_err_acc;
    logic [WIDTH-1:0] r_j;
    logic [WIDTH-1:0] r_k;
    logic [WIDTH-1:0] r_q_snap;
    logic [WIDTH-1:0] w_dec;
    logic [WIDTH-1:0] w_j_nxt;
    logic [WIDTH-1:0] w_k_nxt;
    logic             w_accept;
    logic             w_idx_ok;
    logic             w_q_cur;

    // One-hot decode of the requested index; out-of-range indices decode to zero.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_dec
            assign w_dec[gi] = (int'(cmd_idx) == gi);
        end
    endgenerate

    assign w_idx_ok = (int'(cmd_idx) < WIDTH);
    assign w_accept = cmd_valid && (r_state == c_st_idle);
    assign w_q_cur  = |(q_i & r_sel);

    always_comb begin
        w_next  = r_state;
        w_j_nxt = '0;
        w_k_nxt = '0;
        case (r_state)
            c_st_idle: begin
                if (w_accept) begin
                    if (w_idx_ok) begin
                        w_next  = c_st_apply;
                        w_j_nxt = cmd_op[1] ? w_dec : '0;
                        w_k_nxt = cmd_op[0] ? w_dec : '0;
                    end else begin
                        w_next = c_st_done;
                    end
                end
            end
            c_st_apply: w_next = c_st_check;
            c_st_check: begin
                if (r_rem == '0) begin
                    w_next = c_st_done;
                end else begin
                    w_next  = c_st_apply;
                    w_j_nxt = r_op[1] ? r_sel : '0;
                    w_k_nxt = r_op[0] ? r_sel : '0;
                end
            end
            default: w_next = c_st_idle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_st_idle;
            r_op      <= c_op_hold;
            r_sel     <= '0;
            r_rem     <= '0;
            r_exp     <= 1'b0;
            r_err_acc <= 1'b0;
            r_j       <= '0;
            r_k       <= '0;
            r_q_snap  <= '0;
        end else begin
            r_state <= w_next;
            r_j     <= w_j_nxt;
            r_k     <= w_k_nxt;
            case (r_state)
                c_st_idle: begin
                    if (w_accept) begin
                        r_op      <= cmd_op;
                        r_sel     <= w_dec;
                        r_rem     <= cmd_rep;
                        r_exp     <= |(q_i & w_dec);
                        r_err_acc <= !w_idx_ok;
                    end
                end
                c_st_apply: begin
                    // Expected Q once the cell samples this pulse.
                    case (r_op)
                        c_op_hold:  r_exp <= r_exp;
                        c_op_reset: r_exp <= 1'b0;
                        c_op_set:   r_exp <= 1'b1;
                        default:    r_exp <= ~r_exp;
                    endcase
                end
                c_st_check: begin
                    if (w_q_cur != r_exp) begin
                        r_err_acc <= 1'b1;
                    end
                    if (r_rem == '0) begin
                        r_q_snap <= q_i;
                    end else begin
                        r_rem <= r_rem - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign cmd_ready = (r_state == c_st_idle);
    assign busy      = (r_state != c_st_idle);
    assign done      = (r_state == c_st_done);
    assign err       = done && r_err_acc;
    assign j_o       = r_j;
    assign k_o       = r_k;
    assign q_snap    = r_q_snap;

endmodule
`default_nettype wire

// File: tb/tb_jk_bank_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_jk_bank_seq
// Description : Scoreboard bench for jk_bank_seq driving a behavioural JK bank.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_jk_bank_seq;
    localparam int WIDTH = 8;
    localparam int IDX_W = 4;
    localparam int REP_W = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [1:0]       cmd_op = '0;
    logic [IDX_W-1:0] cmd_idx = '0;
    logic [REP_W-1:0] cmd_rep = '0;
    logic [WIDTH-1:0] q_i;
    logic [WIDTH-1:0] j_o;
    logic [WIDTH-1:0] k_o;
    logic             busy;
    logic             done;
    logic             err;
    logic [WIDTH-1:0] q_snap;

    logic [WIDTH-1:0] bank = '0;
    logic [WIDTH-1:0] stuck = '0;
    logic [WIDTH-1:0] model_snap = '0;
    int               cyc = 0;
    int               n_cmp = 0;
    int               n_fail = 0;

    typedef struct {
        logic             err;
        logic [WIDTH-1:0] snap;
        int               lat;
        int               pulses;
        int               seen;
        logic [WIDTH-1:0] ej;
        logic [WIDTH-1:0] ek;
        int               acc_cyc;
    } exp_t;
    exp_t sb[$];

    jk_bank_seq #(.WIDTH(WIDTH), .IDX_W(IDX_W), .REP_W(REP_W)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_idx(cmd_idx), .cmd_rep(cmd_rep), .q_i(q_i),
        .j_o(j_o), .k_o(k_o), .busy(busy), .done(done), .err(err), .q_snap(q_snap)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural JK cells; stuck bits read as 0 on the Q bus.
    assign q_i = bank & ~stuck;
    always @(posedge clk) begin
        for (int i = 0; i < WIDTH; i++) begin
            case ({j_o[i], k_o[i]})
                2'b01:   bank[i] <= 1'b0;
                2'b10:   bank[i] <= 1'b1;
                2'b11:   bank[i] <= ~bank[i];
                default: bank[i] <= bank[i];
            endcase
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    task automatic fail_now(input string nm);
        n_cmp++;
        n_fail++;
        $display("FAIL %s (t=%0t)", nm, $time);
    endtask

    // Reference model: outcome of a whole command from the rules, in closed form.
    function automatic exp_t model(input logic [1:0] op, input int idx, input int rep,
                                   input logic [WIDTH-1:0] q_now, input logic [WIDTH-1:0] stk);
        exp_t e;
        logic v;
        e.seen = 0;
        e.acc_cyc = 0;
        if (idx >= WIDTH) begin
            e.err = 1'b1;
            e.snap = model_snap;
            e.lat = 1;
            e.pulses = 0;
            e.ej = '0;
            e.ek = '0;
        end else begin
            v = q_now[idx];
            case (op)
                2'b00:   v = v;
                2'b01:   v = 1'b0;
                2'b10:   v = 1'b1;
                default: v = v ^ (((rep + 1) % 2) == 1);
            endcase
            e.err = stk[idx] && op[1];
            e.snap = q_now;
            e.snap[idx] = stk[idx] ? 1'b0 : v;
            e.lat = 2 * (rep + 1) + 1;
            e.pulses = (op == 2'b00) ? 0 : rep + 1;
            e.ej = op[1] ? (WIDTH'(1) << idx) : '0;
            e.ek = op[0] ? (WIDTH'(1) << idx) : '0;
        end
        return e;
    endfunction

    task automatic issue(input logic [1:0] op, input int idx, input int rep);
        exp_t e;
        int n;
        cmd_op = op;
        cmd_idx = IDX_W'(idx);
        cmd_rep = REP_W'(rep);
        cmd_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!cmd_ready && n < 200);
        if (!cmd_ready) begin
            fail_now("accept_timeout");
            cmd_valid = 1'b0;
            return;
        end
        e = model(op, idx, rep, q_i, stuck);
        e.acc_cyc = cyc;
        model_snap = e.snap;
        sb.push_back(e);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_op = 2'($urandom);
        cmd_idx = IDX_W'($urandom);
        cmd_rep = REP_W'($urandom);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            fail_now("done_timeout");
            sb.delete();
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: validates every J/K pulse and every done against the scoreboard head.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if ((j_o | k_o) != '0) begin
                if (sb.size() == 0) begin
                    fail_now("stray_jk");
                end else begin
                    chk("pulse_j", 64'(j_o), 64'(sb[0].ej));
                    chk("pulse_k", 64'(k_o), 64'(sb[0].ek));
                    sb[0].seen++;
                end
            end
            if (done) begin
                if (sb.size() == 0) begin
                    fail_now("stray_done");
                end else begin
                    e = sb.pop_front();
                    chk("done_err", 64'(err), 64'(e.err));
                    chk("done_snap", 64'(q_snap), 64'(e.snap));
                    chk("done_latency", 64'(cyc - e.acc_cyc), 64'(e.lat));
                    chk("pulse_count", 64'(e.seen), 64'(e.pulses));
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin
        int gap;
        cmd_valid = 1'b1;
        cmd_op = 2'b10;
        cmd_idx = 4'd3;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 64'(cmd_ready), 64'd1);
        chk("rst_j", 64'(j_o), 64'd0);
        chk("rst_k", 64'(k_o), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_snap", 64'(q_snap), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cmd_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        issue(2'b10, 3, 0);
        drain();
        chk("set3_snap", 64'(q_snap), 64'h08);
        issue(2'b11, 0, 4);
        drain();
        issue(2'b01, 9, 0);
        drain();
        stuck = 8'h04;
        issue(2'b10, 2, 1);
        drain();
        stuck = '0;

        // Reset during the second APPLY of a toggle command.
        issue(2'b11, 5, 3);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        model_snap = '0;
        @(negedge clk);
        chk("abort_ready", 64'(cmd_ready), 64'd1);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_jk", 64'(j_o | k_o), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        @(posedge clk);
        #1;
        issue(2'b10, 6, 0);
        drain();

        issue(2'b00, 1, 15);
        issue(2'b11, 7, 15);
        drain();

        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(0, 3) == 0) begin
                drain();
                stuck = ($urandom_range(0, 2) == 0) ? (WIDTH'(1) << $urandom_range(0, WIDTH - 1)) : '0;
            end
            issue(2'($urandom), int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
            gap = int'($urandom_range(0, 2));
            repeat (gap) @(posedge clk);
            #1;
        end
        drain();
        repeat (3) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
